// File: rtl/bus_region_pkg.sv
// Shared types for the bus region controller: FSM state encoding and unmapped read fill.
// Combinational definitions only; no latency or backpressure of its own.
package bus_region_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [63:0] UNMAPPED_RD = '1;

endpackage

// File: rtl/bus_region_decode.sv
// Priority page-range decoder: lowest-index region whose inclusive [lo,hi] page range holds the page.
// Purely combinational (0 cycles); no backpressure.
module bus_region_decode
    import bus_region_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int PAGE_W      = 4,
    parameter int IDX_W       = 2
) (
    input  logic [PAGE_W-1:0]             i_page,
    input  logic [NUM_REGIONS*PAGE_W-1:0] i_page_lo,
    input  logic [NUM_REGIONS*PAGE_W-1:0] i_page_hi,
    output logic                          o_hit_vld,
    output logic [IDX_W-1:0]              o_hit_idx
);

    always_comb begin
        o_hit_vld = 1'b0;
        o_hit_idx = '0;
        // Scan downward so the lowest matching index is the one left standing.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((i_page >= i_page_lo[i*PAGE_W +: PAGE_W]) &&
                (i_page <= i_page_hi[i*PAGE_W +: PAGE_W])) begin
                o_hit_vld = 1'b1;
                o_hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_region_ctrl.sv
// CPU bus region controller: chip select, wait states, read mux; BUS_REGION_WP_EN adds write protect.
// Access takes W+1 cycles with cpu_rdy low W cycles; read data appears one cycle after completion.
module bus_region_ctrl
    import bus_region_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int PAGE_W      = 4,
    parameter int WAIT_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic                          cpu_we_n,
    input  logic [NUM_REGIONS*PAGE_W-1:0] page_lo,
    input  logic [NUM_REGIONS*PAGE_W-1:0] page_hi,
    input  logic [NUM_REGIONS*WAIT_W-1:0] wait_cnt,
    input  logic [NUM_REGIONS*DATA_W-1:0] region_di,
`ifdef BUS_REGION_WP_EN
    input  logic [NUM_REGIONS-1:0]        region_wp,
    output logic                          wp_violation,
`endif
    output logic [NUM_REGIONS-1:0]        region_cs,
    output logic                          rd_stb,
    output logic                          wr_stb,
    output logic                          cpu_rdy,
    output logic [DATA_W-1:0]             cpu_di,
    output logic                          unmapped
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    state_t            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_we_n, w_we_n_nxt;
    logic [IDX_W-1:0]  r_rd_idx, w_rd_idx_nxt;
    logic              r_rd_unm, w_rd_unm_nxt;
    logic              r_unmapped, w_unmapped_nxt;

    logic [PAGE_W-1:0]      w_page;
    logic                   w_hit_vld;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [WAIT_W-1:0]      w_hit_wait;
    logic [WAIT_W-1:0]      w_wait_arr [NUM_REGIONS];
    logic [DATA_W-1:0]      w_di_arr   [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] w_cs;
    logic                   w_rdy, w_rd, w_wr;
    logic                   w_fin, w_fin_we_n, w_blocked;
    logic [IDX_W-1:0]       w_fin_idx;

    assign w_page = cpu_addr[ADDR_W-1 -: PAGE_W];

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_unpack
        assign w_wait_arr[g] = wait_cnt[g*WAIT_W +: WAIT_W];
        assign w_di_arr[g]   = region_di[g*DATA_W +: DATA_W];
    end

    bus_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .PAGE_W      (PAGE_W),
        .IDX_W       (IDX_W)
    ) u_decode (
        .i_page    (w_page),
        .i_page_lo (page_lo),
        .i_page_hi (page_hi),
        .o_hit_vld (w_hit_vld),
        .o_hit_idx (w_hit_idx)
    );

    assign w_hit_wait = w_wait_arr[w_hit_idx];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_we_n_nxt     = r_we_n;
        w_rd_idx_nxt   = r_rd_idx;
        w_rd_unm_nxt   = r_rd_unm;
        w_unmapped_nxt = r_unmapped;
        w_cs           = '0;
        w_rdy          = 1'b1;
        w_rd           = 1'b0;
        w_wr           = 1'b0;
        w_fin          = 1'b0;
        w_fin_idx      = r_idx;
        w_fin_we_n     = r_we_n;
        w_blocked      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_hit_vld) begin
                    w_cs[w_hit_idx] = 1'b1;
                    w_idx_nxt       = w_hit_idx;
                    w_we_n_nxt      = cpu_we_n;
                    if (w_hit_wait == '0) begin
                        w_fin      = 1'b1;
                        w_fin_idx  = w_hit_idx;
                        w_fin_we_n = cpu_we_n;
                    end else begin
                        w_rdy       = 1'b0;
                        w_cnt_nxt   = w_hit_wait - 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_unmapped_nxt = 1'b1;
                    w_rd_unm_nxt   = 1'b1;
                end
            end
            ST_WAIT: begin
                // Select stays on the index latched at access start, whatever the address does now.
                w_cs[r_idx] = 1'b1;
                if (r_cnt != '0) begin
                    w_rdy     = 1'b0;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_fin       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase

`ifdef BUS_REGION_WP_EN
        w_blocked = w_fin & ~w_fin_we_n & region_wp[w_fin_idx];
`endif

        if (w_fin) begin
            w_rd         = w_fin_we_n;
            w_wr         = ~w_fin_we_n & ~w_blocked;
            w_rd_idx_nxt = w_fin_idx;
            w_rd_unm_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_we_n     <= 1'b1;
            r_rd_idx   <= '0;
            r_rd_unm   <= 1'b1;
            r_unmapped <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_we_n     <= w_we_n_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_rd_unm   <= w_rd_unm_nxt;
            r_unmapped <= w_unmapped_nxt;
        end
    end

`ifdef BUS_REGION_WP_EN
    logic r_wp_viol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp_viol <= 1'b0;
        end else begin
            r_wp_viol <= r_wp_viol | w_blocked;
        end
    end

    assign wp_violation = r_wp_viol;
`endif

    // Mealy outputs are gated so reset quiets the bus immediately, not at the next edge.
    assign region_cs = reset ? '0 : w_cs;
    assign cpu_rdy   = reset | w_rdy;
    assign rd_stb    = ~reset & w_rd;
    assign wr_stb    = ~reset & w_wr;
    assign cpu_di    = r_rd_unm ? UNMAPPED_RD[DATA_W-1:0] : w_di_arr[r_rd_idx];
    assign unmapped  = r_unmapped;

endmodule

// File: tb/tb_bus_region_ctrl.sv
// Vector table of CPU accesses checked cycle by cycle; read data goes through a scoreboard queue.
module tb_bus_region_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_we_n;
    logic [15:0] page_lo;
    logic [15:0] page_hi;
    logic [15:0] wait_cnt;
    logic [31:0] region_di;
    logic [3:0]  region_cs;
    logic        rd_stb;
    logic        wr_stb;
    logic        cpu_rdy;
    logic [7:0]  cpu_di;
    logic        unmapped;
    logic [3:0]  wp_mask;
`ifdef BUS_REGION_WP_EN
    logic [3:0]  region_wp;
    logic        wp_violation;
`endif

    typedef struct {
        logic [15:0] addr;
        logic        we_n;
        int          cfg;
        logic        unm;
        logic [1:0]  idx;
        int          w;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] di_tab [4];
    logic [7:0] sb_q [$];
    logic       exp_unm;
    logic       exp_wp;
    int         n_chk;
    int         n_err;

    bus_region_ctrl #(
        .NUM_REGIONS (4),
        .ADDR_W      (16),
        .DATA_W      (8),
        .PAGE_W      (4),
        .WAIT_W      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_we_n     (cpu_we_n),
        .page_lo      (page_lo),
        .page_hi      (page_hi),
        .wait_cnt     (wait_cnt),
        .region_di    (region_di),
`ifdef BUS_REGION_WP_EN
        .region_wp    (region_wp),
        .wp_violation (wp_violation),
`endif
        .region_cs    (region_cs),
        .rd_stb       (rd_stb),
        .wr_stb       (wr_stb),
        .cpu_rdy      (cpu_rdy),
        .cpu_di       (cpu_di),
        .unmapped     (unmapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Region map: cfg0 = {0:0x0-0xC, 1:0xD, 2:0xE-0xF, 3:empty}; cfg1 widens region 0 to 0xD; cfg2 drops page 0xE.
    task automatic set_cfg(input int cfg);
        case (cfg)
            1:       begin page_lo = 16'hFED0; page_hi = 16'h0FDD; end
            2:       begin page_lo = 16'hFFD0; page_hi = 16'h0FDC; end
            default: begin page_lo = 16'hFED0; page_hi = 16'h0FDC; end
        endcase
    endtask

    task automatic pop_di();
        logic [7:0] e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("cpu_di", {24'h0, cpu_di}, {24'h0, e});
        end
    endtask

    task automatic sample(input logic [3:0] ecs, input logic erdy, input logic erd, input logic ewr);
        pop_di();
        chk("region_cs", {28'h0, region_cs}, {28'h0, ecs});
        chk("cpu_rdy", {31'h0, cpu_rdy}, {31'h0, erdy});
        chk("rd_stb", {31'h0, rd_stb}, {31'h0, erd});
        chk("wr_stb", {31'h0, wr_stb}, {31'h0, ewr});
        chk("unmapped", {31'h0, unmapped}, {31'h0, exp_unm});
`ifdef BUS_REGION_WP_EN
        chk("wp_violation", {31'h0, wp_violation}, {31'h0, exp_wp});
`endif
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] ecs;
        logic       last;
        ecs = v.unm ? 4'b0000 : (4'b0001 << v.idx);
        for (int c = 0; c <= v.w; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                set_cfg(v.cfg);
                cpu_addr = v.addr;
                cpu_we_n = v.we_n;
            end else begin
                cpu_addr = 16'h0123;
            end
            #4;
            last = (c == v.w);
            sample(ecs, last, last && !v.unm && v.we_n,
                   last && !v.unm && !v.we_n && !wp_mask[v.idx]);
            if (last) begin
                sb_q.push_back(v.unm ? 8'hFF : di_tab[v.idx]);
                if (v.unm) exp_unm = 1'b1;
                if (!v.unm && !v.we_n && wp_mask[v.idx]) exp_wp = 1'b1;
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        exp_unm = 1'b0;
        exp_wp  = 1'b0;
        di_tab[0] = 8'h11;
        di_tab[1] = 8'h22;
        di_tab[2] = 8'h33;
        di_tab[3] = 8'h44;
`ifdef BUS_REGION_WP_EN
        wp_mask   = 4'b0010;
        region_wp = wp_mask;
`else
        wp_mask   = 4'b0000;
`endif
        vecs[0]  = '{addr: 16'h1234, we_n: 1'b1, cfg: 0, unm: 1'b0, idx: 2'd0, w: 0};
        vecs[1]  = '{addr: 16'hD001, we_n: 1'b0, cfg: 0, unm: 1'b0, idx: 2'd1, w: 2};
        vecs[2]  = '{addr: 16'hE000, we_n: 1'b1, cfg: 0, unm: 1'b0, idx: 2'd2, w: 0};
        vecs[3]  = '{addr: 16'hD000, we_n: 1'b1, cfg: 0, unm: 1'b0, idx: 2'd1, w: 2};
        vecs[4]  = '{addr: 16'h0000, we_n: 1'b0, cfg: 0, unm: 1'b0, idx: 2'd0, w: 0};
        vecs[5]  = '{addr: 16'hC000, we_n: 1'b1, cfg: 0, unm: 1'b0, idx: 2'd0, w: 0};
        vecs[6]  = '{addr: 16'hF123, we_n: 1'b1, cfg: 0, unm: 1'b0, idx: 2'd2, w: 0};
        vecs[7]  = '{addr: 16'hD000, we_n: 1'b1, cfg: 1, unm: 1'b0, idx: 2'd0, w: 0};
        vecs[8]  = '{addr: 16'hE000, we_n: 1'b1, cfg: 2, unm: 1'b1, idx: 2'd0, w: 0};
        vecs[9]  = '{addr: 16'h1000, we_n: 1'b1, cfg: 2, unm: 1'b0, idx: 2'd0, w: 0};
        vecs[10] = '{addr: 16'hE555, we_n: 1'b0, cfg: 2, unm: 1'b1, idx: 2'd0, w: 0};

        wait_cnt  = 16'h1020;
        region_di = 32'h44332211;
        set_cfg(0);
        cpu_addr  = 16'hD000;
        cpu_we_n  = 1'b1;
        reset     = 1'b1;

        @(negedge clk);
        chk("rst_region_cs", {28'h0, region_cs}, 32'h0);
        chk("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
        chk("rst_rd_stb", {31'h0, rd_stb}, 32'h0);
        chk("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        chk("rst_cpu_di", {24'h0, cpu_di}, 32'hFF);
        chk("rst_unmapped", {31'h0, unmapped}, 32'h0);

        // First edge after release runs a zero-wait read of region 0.
        cpu_addr = 16'h0000;
        #1;
        reset = 1'b0;
        sb_q.push_back(8'h11);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Reset pulse in the middle of a waited access.
        @(posedge clk);
        #1;
        set_cfg(0);
        cpu_addr = 16'hD000;
        cpu_we_n = 1'b1;
        #4;
        sample(4'b0010, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midwait_region_cs", {28'h0, region_cs}, 32'h0);
        chk("midwait_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
        chk("midwait_rd_stb", {31'h0, rd_stb}, 32'h0);
        chk("midwait_cpu_di", {24'h0, cpu_di}, 32'hFF);
        chk("midwait_unmapped", {31'h0, unmapped}, 32'h0);
        exp_unm = 1'b0;
        exp_wp  = 1'b0;
        #1;
        reset    = 1'b0;
        cpu_addr = 16'h1234;
        #2;
        sample(4'b0001, 1'b1, 1'b1, 1'b0);
        sb_q.push_back(8'h11);
        run_vec(vecs[3]);

        @(posedge clk);
        #5;
        pop_di();
        chk("sb_empty", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
